mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator for the multicycle RISC core. It accepts one memory request at a time from the core's execute/memory stage over a valid/ready handshake. It drives the datamem port (address, datain, memread, memwrite, wrByte), captures dataout, applies byte extension, and returns a one-cycle response. Out-of-range accesses are bounds-checked and faulted without touching memory.

## Interface
- MEM_BYTES, 32: datamem size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- RD_LAT, 1: cycles memread is held before dataout is sampled (≥1).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  controller can accept (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = 16-bit word
- req_signed  in  1  byte loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  16  byte address
- req_wdata  in  16  store data (byte store uses [7:0])
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  16  load result, valid with resp_valid
- resp_fault  out  1  access out of range, valid with resp_valid
- mem_address  out  16  to datamem address
- mem_datain  out  16  to datamem datain
- mem_read  out  1  to datamem memread
- mem_write  out  1  to datamem memwrite
- mem_wrbyte  out  1  to datamem wrByte
- mem_dataout  in  16  from datamem dataout (combinational read, little-endian: {mem[a+1], mem[a]})

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1. On req_valid, capture write/byte/signed/addr/wdata at the edge.
- Fault check at capture: fault if addr ≥ MEM_BYTES, or word access with addr = MEM_BYTES-1. On fault go to RESP with fault=1; no memory strobe is ever asserted.
- Store: go to WRITE. Assert mem_write=1 for exactly one cycle, with mem_wrbyte=req_byte and mem_datain=wdata. datamem commits at the edge ending that cycle. Then go to RESP.
- Load: go to READ. Assert mem_read for RD_LAT cycles; mem_wrbyte=0. At the edge ending the last READ cycle, register the result, then go to RESP:
  - word: mem_dataout
  - byte unsigned: {8'h00, mem_dataout[7:0]}
  - byte signed: {{8{mem_dataout[7]}}, mem_dataout[7:0]}
- RESP: resp_valid=1 for one cycle, then go to IDLE. resp_fault is 1 only for faulted requests.
- resp_rdata is 0 for stores and faults. It holds its value until the next response.
- Word accesses at odd addresses are legal; datamem handles byte addressing.
- mem_read and mem_write are never high together, and never high outside READ/WRITE.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, req_ready=1
  - resp_valid=0, resp_rdata=0, resp_fault=0
  - mem_address=0, mem_datain=0, mem_read=0, mem_write=0, mem_wrbyte=0
- Request accepted at edge E:
  - store: mem_write high in cycle E+1; resp_valid in cycle E+2; req_ready high again in E+3
  - load: mem_read high in cycles E+1..E+RD_LAT; resp_valid in cycle E+RD_LAT+1
  - fault: resp_valid in cycle E+1
- mem_address, mem_datain and mem_wrbyte are stable from the cycle after acceptance through RESP. In IDLE they hold their last values.
- req_ready is low from the cycle after acceptance until IDLE is re-entered. Requests presented meanwhile are ignored (not queued). A core holding req_valid is accepted on the first IDLE cycle.
- Reset asserted mid-transaction:
  - immediate return to IDLE; strobes drop asynchronously
  - no response is issued for the aborted request
  - a store is not committed unless its mem_write edge already occurred

## Test plan
- Store word 0xABCD @0, then load word @0 -> resp_rdata=0xABCD, resp_fault=0; mem_write high exactly 1 cycle; resp_valid 2 cycles after store acceptance.
- Store byte 0xEF @1, then load word @0 -> 0xEFCD. Load byte @1 signed -> 0xFFEF; unsigned -> 0x00EF.
- Store word 0x1234 @2, load byte @3 signed -> 0x0012. With RD_LAT=3: mem_read high 3 cycles; resp_valid 4 cycles after acceptance.
- Word store @31 and byte load @0x0020 -> resp_valid with resp_fault=1, resp_rdata=0, one cycle after acceptance. mem_read and mem_write never asserted; memory unchanged.
- req_valid held high across two back-to-back requests -> second accepted only when req_ready returns. Exactly one resp_valid per request, in order.
- rst pulsed during READ and during WRITE cycle before the edge -> strobes drop immediately, no resp_valid, stored location unchanged. All outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_access_ctrl
// | Single-outstanding load/store initiator for the datamem port. It bounds-checks
// | each request, extends byte loads, and returns a one-cycle response.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_BYTES = 32,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_fault,
  output logic [15:0] mem_address,
  output logic [15:0] mem_datain,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_wrbyte,
  input  logic [15:0] mem_dataout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              CNT_W       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [16:0]     C_LIMIT     = 17'(MEM_BYTES);
  localparam logic [15:0]     C_LAST_ADDR = 16'(MEM_BYTES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_q, byte_d;
  logic             signed_q, signed_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_fault_q, resp_fault_d;
  logic [15:0]      mem_address_q, mem_address_d;
  logic [15:0]      mem_datain_q, mem_datain_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_wrbyte_q, mem_wrbyte_d;

  logic             fault;
  logic [15:0]      load_data;

  // A word access at the last byte would spill past the end of datamem.
  assign fault = ({1'b0, req_addr} >= C_LIMIT) || (!req_byte && (req_addr == C_LAST_ADDR));

  always_comb begin
    load_data = mem_dataout;
    if (byte_q) begin
      load_data = {{8{signed_q & mem_dataout[7]}}, mem_dataout[7:0]};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    signed_d      = signed_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_fault_d  = resp_fault_q;
    mem_address_d = mem_address_q;
    mem_datain_d  = mem_datain_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_wrbyte_d  = mem_wrbyte_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_address_d = req_addr;
          mem_datain_d  = req_wdata;
          mem_wrbyte_d  = req_write & req_byte;
          byte_d        = req_byte;
          signed_d      = req_signed;
          if (fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 16'h0000;
          end else if (req_write) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
          end else begin
            state_d    = S_READ;
            mem_read_d = 1'b1;
            cnt_d      = C_LAST_CNT;
          end
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = 16'h0000;
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = load_data;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          mem_read_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      byte_q        <= 1'b0;
      signed_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 16'h0000;
      resp_fault_q  <= 1'b0;
      mem_address_q <= 16'h0000;
      mem_datain_q  <= 16'h0000;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wrbyte_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      signed_q      <= signed_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_fault_q  <= resp_fault_d;
      mem_address_q <= mem_address_d;
      mem_datain_q  <= mem_datain_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wrbyte_q  <= mem_wrbyte_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign mem_address = mem_address_q;
  assign mem_datain  = mem_datain_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wrbyte  = mem_wrbyte_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_mem_access_ctrl
// | Directed and random load/store traffic against a byte-array reference.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int MEM_BYTES = 32;
  localparam int RD_LAT    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [15:0] resp_rdata;
  logic [15:0] mem_address, mem_datain, mem_dataout;
  logic        mem_read, mem_write, mem_wrbyte;

  logic [7:0]  dmem    [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wrbyte(mem_wrbyte), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // datamem: little-endian, combinational read, write commits on the clock edge
  always @(posedge clk) begin
    if (mem_write && int'(mem_address) < MEM_BYTES) begin
      dmem[int'(mem_address)] <= mem_datain[7:0];
      if (!mem_wrbyte && int'(mem_address) + 1 < MEM_BYTES)
        dmem[int'(mem_address) + 1] <= mem_datain[15:8];
    end
  end

  always_comb begin
    mem_dataout = 16'h0000;
    if (int'(mem_address) + 1 < MEM_BYTES)
      mem_dataout = {dmem[int'(mem_address) + 1], dmem[int'(mem_address)]};
    else if (int'(mem_address) < MEM_BYTES)
      mem_dataout[7:0] = dmem[int'(mem_address)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_ready"},  req_ready,   1);
    chk({tag, ".resp_valid"}, resp_valid,  0);
    chk({tag, ".resp_rdata"}, resp_rdata,  0);
    chk({tag, ".resp_fault"}, resp_fault,  0);
    chk({tag, ".mem_addr"},   mem_address, 0);
    chk({tag, ".mem_datain"}, mem_datain,  0);
    chk({tag, ".mem_strobe"}, {mem_read, mem_write, mem_wrbyte}, 0);
  endtask

  // Issue one request (caller is at a negedge) and check its whole lifetime.
  task automatic run_req(input string tag, input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] d, input bit hold,
                         output logic [15:0] got);
    logic        exp_fault;
    logic [15:0] exp_rdata;
    logic [7:0]  lo, hi;
    int exp_resp, waited;
    int rd_cnt, wr_cnt, rd_first, wr_at, resp_at, resp_cnt;
    int bad_ready, bad_addr, both, wr_bad, rd_bad;
    logic ready_ret;
    logic [15:0] held_rdata;
    logic got_fault;

    exp_fault = (int'(a) >= MEM_BYTES) || (!b && int'(a) == MEM_BYTES - 1);
    exp_rdata = 16'h0000;
    if (!exp_fault && !w) begin
      lo = ref_mem[int'(a)];
      hi = (int'(a) + 1 < MEM_BYTES) ? ref_mem[int'(a) + 1] : 8'h00;
      if (!b)      exp_rdata = {hi, lo};
      else if (s)  exp_rdata = {{8{lo[7]}}, lo};
      else         exp_rdata = {8'h00, lo};
    end
    exp_resp = exp_fault ? 1 : (w ? 2 : RD_LAT + 1);

    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("%s.ready_at_issue", tag), req_ready, 1);
    @(posedge clk);

    if (w && !exp_fault) begin
      ref_mem[int'(a)] = d[7:0];
      if (!b) ref_mem[int'(a) + 1] = d[15:8];
    end

    rd_cnt = 0; wr_cnt = 0; rd_first = 0; wr_at = 0; resp_at = 0; resp_cnt = 0;
    bad_ready = 0; bad_addr = 0; both = 0; wr_bad = 0; rd_bad = 0;
    ready_ret = 1'b0; held_rdata = 16'hxxxx; got = 16'hxxxx; got_fault = 1'bx;
    for (int k = 1; k <= RD_LAT + 6; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (mem_read) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = k;
        if (mem_wrbyte !== 1'b0) rd_bad++;
      end
      if (mem_write) begin
        wr_cnt++;
        wr_at = k;
        if (mem_wrbyte !== b || mem_datain !== d) wr_bad++;
      end
      if (mem_read && mem_write) both++;
      if (resp_valid) begin
        resp_cnt++;
        if (resp_at == 0) begin
          resp_at   = k;
          got       = resp_rdata;
          got_fault = resp_fault;
        end
      end
      if (resp_at == 0 || k == resp_at) begin
        if (req_ready !== 1'b0) bad_ready++;
        if (mem_address !== a) bad_addr++;
      end
      if (resp_at != 0 && k == resp_at + 1) begin
        ready_ret  = req_ready;
        held_rdata = resp_rdata;
        break;
      end
    end

    chk($sformatf("%s.resp_latency", tag), resp_at, exp_resp);
    chk($sformatf("%s.resp_count", tag), resp_cnt, 1);
    chk($sformatf("%s.resp_fault", tag), got_fault, exp_fault);
    chk($sformatf("%s.resp_rdata", tag), got, exp_rdata);
    chk($sformatf("%s.rdata_hold", tag), held_rdata, exp_rdata);
    chk($sformatf("%s.write_cycles", tag), wr_cnt, (w && !exp_fault) ? 1 : 0);
    chk($sformatf("%s.read_cycles", tag), rd_cnt, (!w && !exp_fault) ? RD_LAT : 0);
    if (w && !exp_fault) chk($sformatf("%s.write_at", tag), wr_at, 1);
    if (!w && !exp_fault) chk($sformatf("%s.read_first", tag), rd_first, 1);
    chk($sformatf("%s.ready_low", tag), bad_ready, 0);
    chk($sformatf("%s.ready_return", tag), ready_ret, 1);
    chk($sformatf("%s.addr_stable", tag), bad_addr, 0);
    chk($sformatf("%s.rd_wr_overlap", tag), both, 0);
    chk($sformatf("%s.write_fields", tag), wr_bad, 0);
    chk($sformatf("%s.read_wrbyte", tag), rd_bad, 0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int strobes;
    strobes = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (resp_valid || mem_read || mem_write) strobes++;
    end
    chk({tag, ".no_activity"}, strobes, 0);
  endtask

  initial begin
    logic [15:0] got, d;
    int diff, a;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < MEM_BYTES; i += 2)
      run_req($sformatf("preload%0d", i), 1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom), 1'b0, got);

    run_req("st_w0", 1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD, 1'b0, got);
    run_req("ld_w0", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, got);
    chk("plan.ld_w0", got, 16'hABCD);
    run_req("st_b1", 1'b1, 1'b1, 1'b0, 16'h0001, 16'h77EF, 1'b0, got);
    run_req("ld_w0b", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, got);
    chk("plan.ld_w0b", got, 16'hEFCD);
    run_req("ld_b1s", 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, got);
    chk("plan.ld_b1s", got, 16'hFFEF);
    run_req("ld_b1u", 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, got);
    chk("plan.ld_b1u", got, 16'h00EF);
    run_req("st_w2", 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 1'b0, got);
    run_req("ld_b3s", 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, got);
    chk("plan.ld_b3s", got, 16'h0012);
    run_req("ld_w1odd", 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, got);
    chk("plan.ld_w1odd", got, 16'h34EF);

    run_req("flt_st31", 1'b1, 1'b0, 1'b0, 16'd31, 16'hDEAD, 1'b0, got);
    run_req("flt_ld32", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, got);
    run_req("ok_b31", 1'b0, 1'b1, 1'b0, 16'd31, 16'h0000, 1'b0, got);
    run_req("flt_stFFFF", 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h00AA, 1'b0, got);

    // core keeps req_valid high; the next request is taken when ready returns
    run_req("held_a", 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b1, got);
    run_req("held_b", 1'b1, 1'b0, 1'b0, 16'h0004, 16'h5A5A, 1'b0, got);

    // reset in the middle of a load
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0006;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_rd.read_before", mem_read, 1);
    rst = 1'b1;
    #1;
    chk("rst_rd.read_dropped", mem_read, 0);
    chk_reset("rst_rd");
    @(negedge clk);
    rst = 1'b0;
    watch_idle("rst_rd", 6);

    // reset during the write cycle, before its commit edge
    a = 8;
    d = ~{ref_mem[a + 1], ref_mem[a]};
    req_write = 1'b1; req_byte = 1'b0; req_addr = 16'(a); req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_wr.write_before", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("rst_wr.write_dropped", mem_write, 0);
    chk_reset("rst_wr");
    @(negedge clk);
    rst = 1'b0;
    watch_idle("rst_wr", 4);
    run_req("rst_wr.reload", 1'b0, 1'b0, 1'b0, 16'(a), 16'h0000, 1'b0, got);
    run_req("post_rst_st", 1'b1, 1'b1, 1'b0, 16'd9, 16'h0042, 1'b0, got);

    for (int n = 0; n < 40; n++)
      run_req($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom_range(0, MEM_BYTES + 2)), 16'($urandom), 1'b0, got);

    watch_idle("tail", 3);
    diff = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (dmem[i] !== ref_mem[i]) diff++;
    chk("mem_image", diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
